// File: rtl/core_dout_arbiter.sv
// Round-robin reader of the per-core result FIFOs: drains one PKT_NIBBLES-nibble
// packet from the selected core, tags it with the core index and offers it downstream.
module core_dout_arbiter #(
  parameter int N_CORES     = 4,
  parameter int CORE_ID_W   = 4,
  parameter int PKT_NIBBLES = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic [4*N_CORES-1:0]     din,
  input  logic [N_CORES-1:0]       empty,
  output logic [N_CORES-1:0]       rd_en,
  input  logic [N_CORES-1:0]       err_core_dout,
  output logic [4*PKT_NIBBLES-1:0] pkt_dout,
  output logic [CORE_ID_W-1:0]     pkt_core_id,
  output logic                     pkt_valid,
  input  logic                     pkt_rd_en,
  output logic                     err_timeout,
  output logic                     err_any
);

  localparam int CNT_W = (PKT_NIBBLES > 1) ? $clog2(PKT_NIBBLES) : 1;
  localparam int ST_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {SCAN, READ, OUT} state_t;

  state_t               state, state_nx;
  logic [CORE_ID_W-1:0] ptr, sel, scan_idx, sel_inc;
  logic [CNT_W-1:0]     cnt;
  logic [ST_W-1:0]      stall;
  logic                 found, sel_empty, take, last, tmo;
  logic [3:0]           sel_din;

  // Pick the non-empty core with the smallest wrapped distance from ptr.
  always_comb begin : scan_blk
    int best;
    found    = 1'b0;
    scan_idx = '0;
    best     = N_CORES;
    for (int i = 0; i < N_CORES; i++) begin
      int d;
      d = i - int'(ptr);
      if (d < 0) d += N_CORES;
      if (!empty[i] && d < best) begin
        best     = d;
        found    = 1'b1;
        scan_idx = CORE_ID_W'(i);
      end
    end
  end

  always_comb begin
    sel_empty = 1'b1;
    sel_din   = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (CORE_ID_W'(i) == sel) begin
        sel_empty = empty[i];
        sel_din   = din[4*i +: 4];
      end
    end
  end

  assign take      = (state == READ) && !sel_empty;
  assign last      = take && (cnt == CNT_W'(PKT_NIBBLES - 1));
  assign tmo       = (state == READ) && sel_empty && (stall == ST_W'(TIMEOUT - 1));
  assign sel_inc   = (sel == CORE_ID_W'(N_CORES - 1)) ? '0 : sel + 1'b1;
  assign pkt_valid = (state == OUT);

  always_comb begin
    rd_en = '0;
    for (int i = 0; i < N_CORES; i++)
      rd_en[i] = take && (CORE_ID_W'(i) == sel);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= SCAN;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      SCAN:    if (found) state_nx = READ;
      READ:    if (last) state_nx = OUT;
               else if (tmo) state_nx = SCAN;
      OUT:     if (pkt_rd_en) state_nx = SCAN;
      default: state_nx = SCAN;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ptr         <= '0;
      sel         <= '0;
      cnt         <= '0;
      stall       <= '0;
      pkt_dout    <= '0;
      pkt_core_id <= '0;
      err_timeout <= 1'b0;
      err_any     <= 1'b0;
    end else begin
      err_any <= err_any | (|err_core_dout);
      case (state)
        SCAN: if (found) begin
          sel   <= scan_idx;
          cnt   <= '0;
          stall <= '0;
        end
        READ: if (take) begin
          for (int j = 0; j < PKT_NIBBLES; j++)
            if (CNT_W'(j) == cnt) pkt_dout[4*j +: 4] <= sel_din;
          cnt   <= cnt + 1'b1;
          stall <= '0;
          if (last) pkt_core_id <= sel;
        end else if (tmo) begin
          // Partial packet is abandoned; the core loses its turn.
          err_timeout <= 1'b1;
          ptr         <= sel_inc;
        end else begin
          stall <= stall + 1'b1;
        end
        OUT: if (pkt_rd_en) ptr <= sel_inc;
        default: ;
      endcase
    end
  end

endmodule
